cub_mem_req_issue: RTL



---
 rtl/cub_mem_req_issue_if.sv | 53 +++++
 rtl/cub_mem_req_issue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cub_mem_req_issue_if.sv
// rtl/cub_mem_req_issue_if.sv - EX-side request bus and controller-side issue bus of cub_mem_req_issue
interface cub_mem_req_issue_if;
   logic        ex_mem_valid;
   logic        ex_mem_ready;
   logic        ex_mem_flush;
   logic [1:0]  ex_mem_sel;
   logic        ex_mem_we;
   logic [1:0]  ex_mem_data_type;
   logic        ex_mem_rdata_sign_ext;
   logic [4:0]  ex_mem_rdst_greg;
   logic [31:0] ex_mem_operand_a;
   logic [31:0] ex_mem_operand_b;
   logic [31:0] ex_mem_wr_data;

   logic        cub_mem_op_enable;
   logic [1:0]  cub_mem_sel;
   logic        cub_mem_we;
   logic [1:0]  cub_mem_data_type;
   logic        cub_mem_rdata_sign_ext;
   logic [4:0]  cub_mem_rdst_greg_in;
   logic [31:0] cub_mem_operand_a;
   logic [31:0] cub_mem_operand_b;
   logic [31:0] cub_mem_wr_data;
   logic        cub_mem_op_sta_clr;
   logic        cub_mif_data_l1b_gnt;
   logic        cub_mif_data_cram_gnt;
   logic        cub_mif_data_scache_gnt;
   logic        cub_mem_rvalid;

   modport slave (
      input  ex_mem_valid, ex_mem_flush, ex_mem_sel, ex_mem_we, ex_mem_data_type,
             ex_mem_rdata_sign_ext, ex_mem_rdst_greg, ex_mem_operand_a, ex_mem_operand_b,
             ex_mem_wr_data,
      output ex_mem_ready,
      output cub_mem_op_enable, cub_mem_sel, cub_mem_we, cub_mem_data_type,
             cub_mem_rdata_sign_ext, cub_mem_rdst_greg_in, cub_mem_operand_a,
             cub_mem_operand_b, cub_mem_wr_data, cub_mem_op_sta_clr,
      input  cub_mif_data_l1b_gnt, cub_mif_data_cram_gnt, cub_mif_data_scache_gnt,
             cub_mem_rvalid
   );

   modport master (
      output ex_mem_valid, ex_mem_flush, ex_mem_sel, ex_mem_we, ex_mem_data_type,
             ex_mem_rdata_sign_ext, ex_mem_rdst_greg, ex_mem_operand_a, ex_mem_operand_b,
             ex_mem_wr_data,
      input  ex_mem_ready,
      input  cub_mem_op_enable, cub_mem_sel, cub_mem_we, cub_mem_data_type,
             cub_mem_rdata_sign_ext, cub_mem_rdst_greg_in, cub_mem_operand_a,
             cub_mem_operand_b, cub_mem_wr_data, cub_mem_op_sta_clr,
      output cub_mif_data_l1b_gnt, cub_mif_data_cram_gnt, cub_mif_data_scache_gnt,
             cub_mem_rvalid
   );
endinterface

// File: rtl/cub_mem_req_issue.sv
// rtl/cub_mem_req_issue.sv - in-order request queue, bank-grant pop, read credit tracking and flush clear
// QDEPTH must be a power of two and at least 2.
module cub_mem_req_issue #(
   parameter int QDEPTH             = 2,
   parameter int MAX_RD_OUTSTANDING = 4,
   parameter int CNT_W              = 3
) (
   input  logic               clk,
   input  logic               rst,
   cub_mem_req_issue_if.slave bus,
   output logic [CNT_W-1:0]   rd_outstanding,
   output logic               rsp_err,
   output logic               idle
);
   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0]      OCC_FULL = (AW+1)'(QDEPTH);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_RD_OUTSTANDING);

   typedef struct packed {
      logic [1:0]  sel;
      logic        we;
      logic [1:0]  data_type;
      logic        sign_ext;
      logic [4:0]  rdst;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [31:0] wdata;
   } op_t;

   op_t              mem_q [QDEPTH];
   op_t              mem_d [QDEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             clr_q, clr_d;

   op_t  in_op, head, out_op;
   logic empty, full, ready, op_en, sel_gnt;
   logic push, pop, rd_pop, rv;

   always_comb begin
      in_op = '{sel:       bus.ex_mem_sel,
                we:        bus.ex_mem_we,
                data_type: bus.ex_mem_data_type,
                sign_ext:  bus.ex_mem_rdata_sign_ext,
                rdst:      bus.ex_mem_rdst_greg,
                opa:       bus.ex_mem_operand_a,
                opb:       bus.ex_mem_operand_b,
                wdata:     bus.ex_mem_wr_data};
      head  = mem_q[rd_ptr_q];
      empty = (occ_q == '0);
      full  = (occ_q == OCC_FULL);
      ready = !full && !bus.ex_mem_flush && !clr_q;
      // Writes never consume read credit, so only reads are throttled.
      op_en = !empty && !clr_q && (head.we || (cnt_q < MAX_CNT));
      unique case (head.sel)
         2'b00:   sel_gnt = bus.cub_mif_data_l1b_gnt;
         2'b01:   sel_gnt = bus.cub_mif_data_cram_gnt;
         default: sel_gnt = bus.cub_mif_data_scache_gnt;
      endcase
      pop    = op_en && sel_gnt && !bus.ex_mem_flush;
      push   = bus.ex_mem_valid && ready;
      rd_pop = pop && !head.we;
      rv     = bus.cub_mem_rvalid && !clr_q;
      out_op = empty ? '0 : head;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      clr_d    = bus.ex_mem_flush;
      if (bus.ex_mem_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_op;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            occ_d = occ_q + (AW+1)'(1);
         end else if (pop && !push) begin
            occ_d = occ_q - (AW+1)'(1);
         end
         // A response with nothing tracked is a protocol error, not a wrap.
         if (rd_pop && !rv) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (rv && !rd_pop) begin
            if (cnt_q == '0) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         clr_q    <= clr_d;
      end
      mem_q <= mem_d;
   end

   assign bus.ex_mem_ready           = ready;
   assign bus.cub_mem_op_enable      = op_en;
   assign bus.cub_mem_op_sta_clr     = clr_q;
   assign bus.cub_mem_sel            = out_op.sel;
   assign bus.cub_mem_we             = out_op.we;
   assign bus.cub_mem_data_type      = out_op.data_type;
   assign bus.cub_mem_rdata_sign_ext = out_op.sign_ext;
   assign bus.cub_mem_rdst_greg_in   = out_op.rdst;
   assign bus.cub_mem_operand_a      = out_op.opa;
   assign bus.cub_mem_operand_b      = out_op.opb;
   assign bus.cub_mem_wr_data        = out_op.wdata;

   assign rd_outstanding = cnt_q;
   assign rsp_err        = err_q;
   assign idle           = empty && (cnt_q == '0);
endmodule
